// File: rtl/ps_pkg.sv
// Shared constants and state encoding for the serializer-lane scheduler.
package ps_pkg;
    localparam logic [7:0] COMMA_K28_5 = 8'hBC;
    localparam int         WORD_BITS   = 8;
    localparam int         BIT_CNT_W   = 3;

    typedef enum logic {TRAIN, ACTIVE} sched_state_t;
endpackage

// File: rtl/ps_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               any
);
    localparam int unsigned N  = NUM_REQ;
    localparam int          IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any && req[IW'(idx)]) begin
                any            = 1'b1;
                grant[IW'(idx)] = 1'b1;
                grant_idx      = 2'(idx);
            end
        end
    end
endmodule

// File: rtl/ps_tx_scheduler.sv
// Round-robin scheduler feeding one serializer lane in 8-bit-clock word slots.
// Optional skip words every SKIP_INTERVAL data words when PS_SCHED_SKIP_EN is defined.
module ps_tx_scheduler
    import ps_pkg::*;
#(
    parameter int          NUM_REQ     = 2,
    parameter int          TRAIN_WORDS = 4,
`ifdef PS_SCHED_SKIP_EN
    parameter int          SKIP_INTERVAL = 3,
`endif
    parameter logic [7:0]  COMMA       = COMMA_K28_5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [WORD_BITS*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           ser_valid,
    output logic [7:0]                     ser_data_8b,
    output logic                           ser_load,
    output logic                           link_active,
    output logic [1:0]                     grant_id
);
    localparam int TRAIN_W = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

    sched_state_t         state, state_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [TRAIN_W-1:0]   train_cnt;
    logic [1:0]           rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [1:0]           grant_idx;
    logic                 any;
    logic                 boundary, train_last, arb_en, take;
    logic [7:0]           win_data;
    logic [1:0]           ptr_next;
`ifdef PS_SCHED_SKIP_EN
    logic [1:0]           data_cnt;
    logic                 skip_now;
    assign skip_now = (data_cnt == 2'(SKIP_INTERVAL));
`endif

    assign boundary   = (bit_cnt == '1);
    assign train_last = (train_cnt == TRAIN_W'(TRAIN_WORDS - 1));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // The final training boundary already arbitrates so data can start in word TRAIN_WORDS.
    always_comb begin
        state_next = state;
        arb_en     = 1'b0;
        if (boundary) begin
            case (state)
                TRAIN: if (train_last) begin
                    state_next = ACTIVE;
                    arb_en     = 1'b1;
                end
                ACTIVE: arb_en = 1'b1;
                default: state_next = TRAIN;
            endcase
        end
`ifdef PS_SCHED_SKIP_EN
        if (skip_now) arb_en = 1'b0;
`endif
        req_ready = arb_en ? grant : '0;
        take      = arb_en & any;
    end

    always_comb begin
        win_data = COMMA;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 2'(i)) win_data = req_data[i*WORD_BITS +: WORD_BITS];
        end
        ptr_next = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= TRAIN;
            bit_cnt     <= '0;
            train_cnt   <= '0;
            rr_ptr      <= '0;
            ser_data_8b <= COMMA;
            ser_valid   <= 1'b0;
            ser_load    <= 1'b0;
            link_active <= 1'b0;
            grant_id    <= '0;
`ifdef PS_SCHED_SKIP_EN
            data_cnt    <= '0;
`endif
        end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            ser_load <= boundary;
            state    <= state_next;
            if (boundary) begin
                link_active <= (state_next == ACTIVE);
                if (state == TRAIN) train_cnt <= train_cnt + 1'b1;
                if (take) begin
                    ser_data_8b <= win_data;
                    ser_valid   <= 1'b1;
                    grant_id    <= grant_idx;
                    rr_ptr      <= ptr_next;
`ifdef PS_SCHED_SKIP_EN
                    data_cnt    <= data_cnt + 2'd1;
`endif
                end else begin
                    ser_data_8b <= COMMA;
                    ser_valid   <= 1'b0;
                    grant_id    <= '0;
`ifdef PS_SCHED_SKIP_EN
                    if (skip_now) data_cnt <= '0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_ps_tx_scheduler.sv
// Directed bench for ps_tx_scheduler; cycle N = N clock edges after reset release.
module tb_ps_tx_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        ser_valid;
    logic [7:0]  ser_data_8b;
    logic        ser_load;
    logic        link_active;
    logic [1:0]  grant_id;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ps_tx_scheduler #(.NUM_REQ(2), .TRAIN_WORDS(4), .COMMA(8'hBC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_valid(ser_valid), .ser_data_8b(ser_data_8b),
        .ser_load(ser_load), .link_active(link_active), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc != n) begin
            failures++;
            $display("FAIL wait_cyc got=%0d exp=%0d", cyc, n);
        end
    endtask

    task automatic test_reset();
        req_valid = '0;
        do_reset();
        for (int c = 0; c <= 47; c++) begin
            wait_cyc(c);
            checks++;
            if (ser_data_8b !== 8'hBC || ser_valid !== 1'b0 || req_ready !== 2'b00 || grant_id !== 2'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h/%b/%b/%0d exp=bc/0/00/0", c, ser_data_8b, ser_valid, req_ready, grant_id);
            end
            checks++;
            if (ser_load !== (c > 0 && c % 8 == 0)) begin
                failures++;
                $display("FAIL reset_load cyc=%0d got=%b exp=%b", c, ser_load, (c > 0 && c % 8 == 0));
            end
            checks++;
            if (link_active !== (c >= 32)) begin
                failures++;
                $display("FAIL reset_link cyc=%0d got=%b exp=%b", c, link_active, (c >= 32));
            end
        end
    endtask

    task automatic test_single();
        logic [1:0] er;
        logic [7:0] ed;
        req_valid = 2'b01;
        req_data  = 16'h00AA;
        do_reset();
        for (int c = 0; c <= 47; c++) begin
            wait_cyc(c);
            er = (c >= 31 && c % 8 == 7) ? 2'b01 : 2'b00;
            ed = (c >= 32) ? 8'hAA : 8'hBC;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL single_ready cyc=%0d got=%b exp=%b", c, req_ready, er);
            end
            checks++;
            if (ser_data_8b !== ed || ser_valid !== (c >= 32) || grant_id !== 2'd0) begin
                failures++;
                $display("FAIL single_word cyc=%0d got=%h/%b/%0d exp=%h/%b/0", c, ser_data_8b, ser_valid, grant_id, ed, (c >= 32));
            end
        end
    endtask

    task automatic test_alternate();
        logic [1:0] er, eg;
        logic [7:0] ed;
        req_valid = 2'b11;
        req_data  = 16'hABAA;
        do_reset();
        for (int c = 0; c <= 54; c++) begin
            wait_cyc(c);
            eg = (c >= 32) ? 2'((c / 8 - 4) % 2) : 2'd0;
            ed = (c < 32) ? 8'hBC : (eg == 2'd1 ? 8'hAB : 8'hAA);
            er = (c >= 31 && c % 8 == 7) ? (((c + 1) / 8 - 4) % 2 == 1 ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL alt_ready cyc=%0d got=%b exp=%b", c, req_ready, er);
            end
            checks++;
            if (ser_data_8b !== ed || ser_valid !== (c >= 32) || grant_id !== eg) begin
                failures++;
                $display("FAIL alt_word cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d", c, ser_data_8b, ser_valid, grant_id, ed, (c >= 32), eg);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] eg;
        logic [7:0] ed;
        req_valid = 2'b11;
        req_data  = 16'hABAA;
        do_reset();
        wait_cyc(45);
        checks++;
        if (ser_data_8b !== 8'hAB || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL mid_before cyc=45 got=%h/%0d exp=ab/1", ser_data_8b, grant_id);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ser_data_8b !== 8'hBC || ser_valid !== 1'b0 || link_active !== 1'b0 || grant_id !== 2'd0 || ser_load !== 1'b0) begin
            failures++;
            $display("FAIL mid_async got=%h/%b/%b/%0d/%b exp=bc/0/0/0/0", ser_data_8b, ser_valid, link_active, grant_id, ser_load);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c <= 47; c++) begin
            wait_cyc(c);
            eg = (c >= 32) ? 2'((c / 8 - 4) % 2) : 2'd0;
            ed = (c < 32) ? 8'hBC : (eg == 2'd1 ? 8'hAB : 8'hAA);
            checks++;
            if (ser_data_8b !== ed || ser_valid !== (c >= 32) || link_active !== (c >= 32) || grant_id !== eg) begin
                failures++;
                $display("FAIL mid_retrain cyc=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", c, ser_data_8b, ser_valid, link_active, grant_id, ed, (c >= 32), (c >= 32), eg);
            end
        end
    endtask

    task automatic test_no_boundary();
        req_valid = 2'b00;
        req_data  = 16'h5500;
        do_reset();
        for (int c = 32; c <= 47; c++) begin
            wait_cyc(c);
            if (c == 33) req_valid = 2'b10;
            if (c == 36) req_valid = 2'b00;
            #1;
            checks++;
            if (req_ready !== 2'b00 || ser_valid !== 1'b0 || ser_data_8b !== 8'hBC || grant_id !== 2'd0) begin
                failures++;
                $display("FAIL pulse_between cyc=%0d got=%b/%b/%h/%0d exp=00/0/bc/0", c, req_ready, ser_valid, ser_data_8b, grant_id);
            end
        end
    endtask

`ifdef PS_SCHED_SKIP_EN
    task automatic test_skip();
        logic [1:0] er;
        logic [7:0] ed;
        logic       sk;
        req_valid = 2'b01;
        req_data  = 16'h00AA;
        do_reset();
        for (int c = 31; c <= 95; c++) begin
            wait_cyc(c);
            sk = (c >= 32) && ((c / 8 - 4) % 4 == 3);
            ed = (c < 32 || sk) ? 8'hBC : 8'hAA;
            er = (c % 8 == 7 && (((c + 1) / 8 - 4) % 4 != 3)) ? 2'b01 : 2'b00;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL skip_ready cyc=%0d got=%b exp=%b", c, req_ready, er);
            end
            checks++;
            if (ser_data_8b !== ed || ser_valid !== (c >= 32 && !sk)) begin
                failures++;
                $display("FAIL skip_word cyc=%0d got=%h/%b exp=%h/%b", c, ser_data_8b, ser_valid, ed, (c >= 32 && !sk));
            end
        end
    endtask
`else
    task automatic test_no_skip();
        req_valid = 2'b01;
        req_data  = 16'h00AA;
        do_reset();
        for (int c = 31; c <= 95; c++) begin
            wait_cyc(c);
            checks++;
            if (req_ready !== ((c % 8 == 7) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL noskip_ready cyc=%0d got=%b exp=%b", c, req_ready, ((c % 8 == 7) ? 2'b01 : 2'b00));
            end
            checks++;
            if (c >= 32 && (ser_data_8b !== 8'hAA || ser_valid !== 1'b1)) begin
                failures++;
                $display("FAIL noskip_word cyc=%0d got=%h/%b exp=aa/1", c, ser_data_8b, ser_valid);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_reset_mid();
        test_no_boundary();
`ifdef PS_SCHED_SKIP_EN
        test_skip();
`else
        test_no_skip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
